// File: rtl/memory_disp_pkg.sv
// Shared types and constants for the memory-game display scanner.
// Optional feature macro: MEMORY_DISP_PEEK_EN (adds the Peek field to the snapshot).
package memory_disp_pkg;

    localparam int unsigned SEG_W  = 7;
    localparam int unsigned FLAG_W = 5;
    localparam int unsigned NIB_W  = 4;

    // One-hot state encodings, ordered {Ql, Qp, Qfo, Qg, Qi}
    localparam logic [FLAG_W-1:0] ST_INITIAL  = 5'b00001;
    localparam logic [FLAG_W-1:0] ST_GENERATE = 5'b00010;
    localparam logic [FLAG_W-1:0] ST_FINDONES = 5'b00100;
    localparam logic [FLAG_W-1:0] ST_PLAY     = 5'b01000;
    localparam logic [FLAG_W-1:0] ST_LOSE     = 5'b10000;

    // Active-low glyphs, bit0 = a .. bit6 = g
    localparam logic [SEG_W-1:0] SEG_BLANK  = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_DASH   = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_L      = 7'h47;
    localparam logic [SEG_W-1:0] SEG_0      = 7'h40;
    localparam logic [SEG_W-1:0] SEG_5      = 7'h12;
    localparam logic [SEG_W-1:0] SEG_E      = 7'h06;
    localparam logic [SEG_W-1:0] SEG_A_ONLY = 7'h7E;
    localparam logic [SEG_W-1:0] SEG_B_ONLY = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_C_ONLY = 7'h7B;
    localparam logic [SEG_W-1:0] SEG_D_ONLY = 7'h77;

    // Frame snapshot of everything the display reads
    typedef struct packed {
        logic [FLAG_W-1:0]           flags;
`ifdef MEMORY_DISP_PEEK_EN
        logic                        peek;
        logic [3:0][NIB_W-1:0]       a;
`endif
        logic [3:0][NIB_W-1:0]       b;
        logic [NIB_W-1:0]            x;
        logic [NIB_W-1:0]            y;
        logic [NIB_W-1:0]            lives;
    } snap_t;

    // Hex digit to active-low segment pattern
    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIB_W-1:0] v);
        logic [SEG_W-1:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/memory_display_scan_seven_seg_hex.sv
// Combinational hex-to-seven-segment decoder (active-low cathodes).
module seven_seg_hex
    import memory_disp_pkg::*;
(
    input  logic [NIB_W-1:0] i_val,
    output logic [SEG_W-1:0] o_seg
);

    // Pure table lookup
    always_comb begin
        o_seg = hex_to_seg(i_val);
    end

endmodule

// File: rtl/memory_display_scan.sv
// 4-digit multiplexed display scanner for the memory-game board outputs.
// Optional feature macro: MEMORY_DISP_PEEK_EN (Peek input shows answer rows in PLAY).
module memory_display_scan
    import memory_disp_pkg::*;
#(
    parameter int unsigned REFRESH_BITS = 17,
    parameter int unsigned BLINK_BITS   = 25
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Qi,
    input  logic             Qg,
    input  logic             Qfo,
    input  logic             Qp,
    input  logic             Ql,
    input  logic [NIB_W-1:0] A0,
    input  logic [NIB_W-1:0] A1,
    input  logic [NIB_W-1:0] A2,
    input  logic [NIB_W-1:0] A3,
    input  logic [NIB_W-1:0] B0,
    input  logic [NIB_W-1:0] B1,
    input  logic [NIB_W-1:0] B2,
    input  logic [NIB_W-1:0] B3,
    input  logic [NIB_W-1:0] X,
    input  logic [NIB_W-1:0] Y,
    input  logic [NIB_W-1:0] Lives,
`ifdef MEMORY_DISP_PEEK_EN
    input  logic             Peek,
`endif
    output logic [3:0]       An,
    output logic [SEG_W-1:0] Seg,
    output logic             Dp
);

    logic [REFRESH_BITS-1:0] r_refresh;
    logic [BLINK_BITS-1:0]   r_blink;
    logic [1:0]              r_digit;
    snap_t                   r_snap;
    logic [3:0]              r_an;
    logic [SEG_W-1:0]        r_seg;
    logic                    r_dp;

    snap_t                   w_in;
    logic                    w_wrap;
    logic                    w_phase;
    logic [1:0]              w_row;
    logic                    w_use_a;
    logic [NIB_W-1:0]        w_hex_val;
    logic [SEG_W-1:0]        w_hex_seg;
    logic [3:0]              w_an_c;
    logic [SEG_W-1:0]        w_seg_c;
    logic                    w_dp_c;

    assign w_wrap  = &r_refresh;
    assign w_phase = r_blink[BLINK_BITS-1];
    assign w_row   = 2'd3 - r_digit;

    // Gather the live inputs into snapshot form
    always_comb begin
        w_in       = '0;
        w_in.flags = {Ql, Qp, Qfo, Qg, Qi};
        w_in.b     = {B3, B2, B1, B0};
        w_in.x     = X;
        w_in.y     = Y;
        w_in.lives = Lives;
`ifdef MEMORY_DISP_PEEK_EN
        w_in.peek  = Peek;
        w_in.a     = {A3, A2, A1, A0};
`endif
    end

`ifdef MEMORY_DISP_PEEK_EN
    assign w_use_a   = r_snap.peek && (r_snap.flags == ST_PLAY);
    assign w_hex_val = w_use_a ? r_snap.a[w_row] : r_snap.b[w_row];
`else
    logic w_unused_a;
    assign w_unused_a = ^{A3, A2, A1, A0};
    assign w_use_a    = 1'b0;
    assign w_hex_val  = r_snap.b[w_row];
`endif

    seven_seg_hex u_hex (
        .i_val (w_hex_val),
        .o_seg (w_hex_seg)
    );

    // Refresh/blink counters, digit index and frame-start snapshot
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_refresh <= '0;
            r_blink   <= '0;
            r_digit   <= 2'd0;
            r_snap    <= '0;
        end else begin
            r_refresh <= r_refresh + REFRESH_BITS'(1);
            r_blink   <= r_blink + BLINK_BITS'(1);
            if (w_wrap) begin
                r_digit <= r_digit + 2'd1;
                if (r_digit == 2'd3) begin
                    r_snap <= w_in;
                end
            end
        end
    end

    // Glyph, cursor and life-dot selection for the current digit
    always_comb begin
        w_an_c  = ~(4'b0001 << r_digit);
        w_seg_c = SEG_BLANK;
        w_dp_c  = 1'b1;
        case (r_snap.flags)
            ST_INITIAL: w_seg_c = SEG_DASH;
            ST_PLAY: begin
                w_seg_c = w_hex_seg;
                if ((r_snap.x < 4'd4) && (r_snap.x[1:0] == w_row) && w_phase) begin
                    case (r_snap.y)
                        4'd0:    w_seg_c = SEG_A_ONLY;
                        4'd1:    w_seg_c = SEG_B_ONLY;
                        4'd2:    w_seg_c = SEG_C_ONLY;
                        4'd3:    w_seg_c = SEG_D_ONLY;
                        default: w_seg_c = SEG_BLANK;
                    endcase
                end
                w_dp_c = !({2'b00, r_digit} < r_snap.lives);
            end
            ST_LOSE: begin
                case (r_digit)
                    2'd3:    w_seg_c = SEG_L;
                    2'd2:    w_seg_c = SEG_0;
                    2'd1:    w_seg_c = SEG_5;
                    default: w_seg_c = SEG_E;
                endcase
            end
            default: w_seg_c = SEG_BLANK;
        endcase
    end

    // Registered pin drivers; reset forces the dark pattern immediately
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_an  <= 4'b1110;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an_c;
            r_seg <= w_seg_c;
            r_dp  <= w_dp_c;
        end
    end

    assign An  = r_an;
    assign Seg = r_seg;
    assign Dp  = r_dp;

endmodule

// File: tb/tb_memory_display_scan.sv
// Testbench for memory_display_scan with REFRESH_BITS=2, BLINK_BITS=4.
// Optional feature macro: MEMORY_DISP_PEEK_EN.
module tb_memory_display_scan;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Qi = 1'b0, Qg = 1'b0, Qfo = 1'b0, Qp = 1'b0, Ql = 1'b0;
    logic [3:0] A0 = '0, A1 = '0, A2 = '0, A3 = '0;
    logic [3:0] B0 = '0, B1 = '0, B2 = '0, B3 = '0;
    logic [3:0] X = '0, Y = '0, Lives = '0;
`ifdef MEMORY_DISP_PEEK_EN
    logic       Peek = 1'b0;
`endif
    logic [3:0] An;
    logic [6:0] Seg;
    logic       Dp;

    int checks = 0;
    int errors = 0;

    memory_display_scan #(.REFRESH_BITS(2), .BLINK_BITS(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .Qi(Qi), .Qg(Qg), .Qfo(Qfo), .Qp(Qp), .Ql(Ql),
        .A0(A0), .A1(A1), .A2(A2), .A3(A3),
        .B0(B0), .B1(B1), .B2(B2), .B3(B3),
        .X(X), .Y(Y), .Lives(Lives),
`ifdef MEMORY_DISP_PEEK_EN
        .Peek(Peek),
`endif
        .An(An), .Seg(Seg), .Dp(Dp)
    );

    always #5 Clk = ~Clk;

    // Reference tables (active-low, bit0 = a)
    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [6:0] one_tab [4]  = '{7'h7E, 7'h7D, 7'h7B, 7'h77};
    logic [6:0] lose_tab [4] = '{7'h06, 7'h12, 7'h40, 7'h47};

    // Behavioural model: clocks since reset and the frame snapshot
    int         cnt = 0;
    logic [4:0] m_flags = '0;
    logic [3:0] m_a [4];
    logic [3:0] m_b [4];
    logic [3:0] m_x = '0, m_y = '0, m_lives = '0;
    logic       m_peek = 1'b0;
    logic [3:0] exp_an = 4'b1110;
    logic [6:0] exp_seg = 7'h7F;
    logic       exp_dp = 1'b1;

    function automatic logic [11:0] predict(input int c);
        int d, r;
        logic [3:0] an, v;
        logic [6:0] seg;
        logic dp;
        d = (c / 4) % 4;
        r = 3 - d;
        an = 4'b1111;
        an[d] = 1'b0;
        seg = 7'h7F;
        dp = 1'b1;
        case (m_flags)
            5'b00001: seg = 7'h3F;
            5'b01000: begin
                v = m_peek ? m_a[r] : m_b[r];
                seg = hex_tab[v];
                if (m_x < 4 && r == int'(m_x) && ((c / 8) % 2) == 1)
                    seg = (m_y < 4) ? one_tab[m_y[1:0]] : 7'h7F;
                dp = (d < int'(m_lives)) ? 1'b0 : 1'b1;
            end
            5'b10000: seg = lose_tab[d];
            default: ;
        endcase
        return {an, seg, dp};
    endfunction

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt = 0;
            m_flags = '0; m_x = '0; m_y = '0; m_lives = '0; m_peek = 1'b0;
            for (int i = 0; i < 4; i++) begin m_a[i] = '0; m_b[i] = '0; end
            exp_an = 4'b1110; exp_seg = 7'h7F; exp_dp = 1'b1;
        end else begin
            {exp_an, exp_seg, exp_dp} = predict(cnt);
            cnt++;
            if (cnt % 16 == 0) begin
                m_flags = {Ql, Qp, Qfo, Qg, Qi};
                m_a[0] = A0; m_a[1] = A1; m_a[2] = A2; m_a[3] = A3;
                m_b[0] = B0; m_b[1] = B1; m_b[2] = B2; m_b[3] = B3;
                m_x = X; m_y = Y; m_lives = Lives;
`ifdef MEMORY_DISP_PEEK_EN
                m_peek = Peek;
`endif
            end
        end
    end

    task automatic set_flags(input logic [4:0] f);
        {Ql, Qp, Qfo, Qg, Qi} = f;
    endtask

    task automatic test_reset();
        set_flags(5'b00001);
        repeat (2) @(negedge Clk);
        checks++;
        if (An !== 4'b1110 || Seg !== 7'h7F || Dp !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold: An=%b Seg=%h Dp=%b expected An=1110 Seg=7f Dp=1", An, Seg, Dp);
        end
        Reset_n = 1'b1;
        for (int i = 0; i < 48; i++) begin
            @(negedge Clk);
            checks++;
            if (An !== exp_an || Seg !== exp_seg || Dp !== exp_dp) begin
                errors++;
                $display("FAIL initial cyc%0d: An=%b Seg=%h Dp=%b expected An=%b Seg=%h Dp=%b",
                         i, An, Seg, Dp, exp_an, exp_seg, exp_dp);
            end
        end
    endtask

    task automatic test_play();
        set_flags(5'b01000);
        B0 = 4'h1; B1 = 4'h2; B2 = 4'hA; B3 = 4'hF;
        X = 4'd4; Y = 4'd0; Lives = 4'd2;
        for (int i = 0; i < 48; i++) begin
            @(negedge Clk);
            checks++;
            if (An !== exp_an || Seg !== exp_seg || Dp !== exp_dp) begin
                errors++;
                $display("FAIL play cyc%0d: An=%b Seg=%h Dp=%b expected An=%b Seg=%h Dp=%b",
                         i, An, Seg, Dp, exp_an, exp_seg, exp_dp);
            end
        end
    endtask

    task automatic test_cursor();
        X = 4'd1; Y = 4'd2;
        for (int i = 0; i < 64; i++) begin
            @(negedge Clk);
            checks++;
            if (An !== exp_an || Seg !== exp_seg || Dp !== exp_dp) begin
                errors++;
                $display("FAIL cursor cyc%0d: An=%b Seg=%h Dp=%b expected An=%b Seg=%h Dp=%b",
                         i, An, Seg, Dp, exp_an, exp_seg, exp_dp);
            end
        end
    endtask

    task automatic test_midframe_change();
        int guard = 0;
        X = 4'd4;
        while (((cnt / 4) % 4) != 1 && guard < 32) begin
            @(negedge Clk);
            guard++;
        end
        checks++;
        if (((cnt / 4) % 4) != 1) begin
            errors++;
            $display("FAIL midframe_sync: digit=%0d expected 1", (cnt / 4) % 4);
        end
        B1 = 4'h7;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            checks++;
            if (An !== exp_an || Seg !== exp_seg || Dp !== exp_dp) begin
                errors++;
                $display("FAIL midframe cyc%0d: An=%b Seg=%h Dp=%b expected An=%b Seg=%h Dp=%b",
                         i, An, Seg, Dp, exp_an, exp_seg, exp_dp);
            end
        end
    endtask

    task automatic test_lose_and_illegal();
        set_flags(5'b10000);
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            checks++;
            if (An !== exp_an || Seg !== exp_seg || Dp !== exp_dp) begin
                errors++;
                $display("FAIL lose cyc%0d: An=%b Seg=%h Dp=%b expected An=%b Seg=%h Dp=%b",
                         i, An, Seg, Dp, exp_an, exp_seg, exp_dp);
            end
        end
        set_flags(5'b01001);
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            checks++;
            if (An !== exp_an || Seg !== exp_seg || Dp !== exp_dp) begin
                errors++;
                $display("FAIL illegal cyc%0d: An=%b Seg=%h Dp=%b expected An=%b Seg=%h Dp=%b",
                         i, An, Seg, Dp, exp_an, exp_seg, exp_dp);
            end
        end
    endtask

    task automatic test_async_reset();
        set_flags(5'b01000);
        X = 4'd2; Y = 4'd1; Lives = 4'd3;
        repeat (22) @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if (An !== 4'b1110 || Seg !== 7'h7F || Dp !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: An=%b Seg=%h Dp=%b expected An=1110 Seg=7f Dp=1", An, Seg, Dp);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int i = 0; i < 48; i++) begin
            @(negedge Clk);
            checks++;
            if (An !== exp_an || Seg !== exp_seg || Dp !== exp_dp) begin
                errors++;
                $display("FAIL post_reset cyc%0d: An=%b Seg=%h Dp=%b expected An=%b Seg=%h Dp=%b",
                         i, An, Seg, Dp, exp_an, exp_seg, exp_dp);
            end
        end
    endtask

`ifdef MEMORY_DISP_PEEK_EN
    task automatic test_peek();
        set_flags(5'b01000);
        Peek = 1'b1; A2 = 4'h9; X = 4'd4;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            checks++;
            if (An !== exp_an || Seg !== exp_seg || Dp !== exp_dp) begin
                errors++;
                $display("FAIL peek cyc%0d: An=%b Seg=%h Dp=%b expected An=%b Seg=%h Dp=%b",
                         i, An, Seg, Dp, exp_an, exp_seg, exp_dp);
            end
        end
        Peek = 1'b0;
    endtask
`endif

    task automatic test_random();
        int sel;
        for (int k = 0; k < 60; k++) begin
            sel = int'($urandom_range(0, 7));
            if (sel < 5) set_flags(5'(1 << sel));
            else if (sel == 5) set_flags(5'($urandom));
            else set_flags(5'b01000);
            A0 = 4'($urandom); A1 = 4'($urandom); A2 = 4'($urandom); A3 = 4'($urandom);
            B0 = 4'($urandom); B1 = 4'($urandom); B2 = 4'($urandom); B3 = 4'($urandom);
            X = 4'($urandom_range(0, 5));
            Y = 4'($urandom_range(0, 5));
            Lives = 4'($urandom_range(0, 6));
`ifdef MEMORY_DISP_PEEK_EN
            Peek = 1'($urandom);
`endif
            for (int i = 0; i < int'($urandom_range(1, 24)); i++) begin
                @(negedge Clk);
                checks++;
                if (An !== exp_an || Seg !== exp_seg || Dp !== exp_dp) begin
                    errors++;
                    $display("FAIL random k%0d: An=%b Seg=%h Dp=%b expected An=%b Seg=%h Dp=%b",
                             k, An, Seg, Dp, exp_an, exp_seg, exp_dp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_play();
        test_cursor();
        test_midframe_change();
        test_lose_and_illegal();
        test_async_reset();
`ifdef MEMORY_DISP_PEEK_EN
        test_peek();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
